sm_serial_alu: RTL
==================

# sm_serial_alu

Parametrised, bit-serial sign-magnitude add/subtract unit with valid/ready handshakes on both sides. Operands are a sign bit plus a MAG_W-bit magnitude. The block computes A+B or A−B one magnitude bit per cycle and returns a registered sign-magnitude result with zero and overflow flags. It is the sequential, width-generic successor to the team's combinational sign-magnitude adder, and it sits between operand registers and the result/display path.

## Interface
- MAG_W, default 4: magnitude width in bits, ≥2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept operands; high only in IDLE.
- op  in  1  0 = add, 1 = subtract (A−B).
- a_sign, b_sign  in  1 each  operand signs; 1 = negative.
- a_mag, b_mag  in  MAG_W each  operand magnitudes.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts result.
- res_sign  out  1  result sign.
- res_mag  out  MAG_W  result magnitude.
- overflow  out  1  true magnitude exceeded 2^MAG_W−1.
- zero_flag  out  1  res_mag == 0.

## Operation
- Accept: an input transfer occurs on a rising edge with in_valid && in_ready. Operands and op are captured, and inputs are ignored afterwards.
- Effective B sign: eb = b_sign ^ op. An input of −0 is treated as +0.
- Same signs (a_sign == eb): the magnitudes are added. res_sign = a_sign. overflow = carry out of bit MAG_W−1. res_mag = low MAG_W bits, wrapped.
- Different signs: the larger magnitude minus the smaller. res_sign = sign of the larger. overflow = 0.
- Equal magnitudes, or both zero: the result is +0. res_sign is forced to 0 whenever the true result is zero. −0 is never produced.
- Overflow with a wrapped magnitude of 0: zero_flag = 1 and res_sign keeps the operand sign.
- FSM states:
  - IDLE: in_ready = 1. On accept, go to CMP.
  - CMP: one cycle. Compare magnitudes, swap so the minuend is the larger, fix sign and add/sub mode, clear the carry/borrow flop and the bit counter. Go to CALC.
  - CALC: MAG_W cycles, LSB first. One result bit and the next carry/borrow per cycle. The counter counts 0..MAG_W−1. After the last bit, go to DONE.
  - DONE: out_valid = 1. When out_ready is high, go to IDLE.
- Results and flags are registered. They stay stable from out_valid rising until the output handshake completes.

## Timing
- Reset (asynchronous, any state): state = IDLE, in_ready = 1. out_valid, res_sign, res_mag, overflow and zero_flag all 0. The carry flop and counter are 0.
- Reset during CMP or CALC aborts the operation. No result is emitted.
- Latency: out_valid rises on the (MAG_W+2)th rising edge after the accepting edge. Edge +1 enters CMP, edge +2 enters CALC, edge +(MAG_W+2) enters DONE.
- Output handshake: the transfer happens on an edge with out_valid && out_ready. out_valid falls on that edge, and in_ready is high in the following cycle.
- Minimum issue interval: MAG_W+4 cycles, because there is no overlap between operations.
- out_ready may be held high permanently. DONE then lasts exactly one cycle.
- out_ready low holds DONE indefinitely. in_ready stays 0 for the whole hold.

## Structure
- Shared package sm_alu_pkg holds:
  - state enum: IDLE, CMP, CALC, DONE;
  - op encoding constants: OP_ADD = 0, OP_SUB = 1;
  - a function for the counter width, $clog2(MAG_W).
- Sub-module sm_serial_bit: a 1-bit full adder/subtractor. Inputs are the minuend bit, the subtrahend bit, carry/borrow in and mode. Outputs are the sum bit and carry/borrow out. It is instantiated once and driven by the shift registers.
- The top holds the FSM, the operand shift registers, the result shift register, the counter and the flag logic.

## Test plan
All scenarios use MAG_W = 4.
- Add, positive operands: +5 add +3 → +8, overflow 0, zero_flag 0. out_valid rises 6 edges after accept.
- Mixed signs: +3 add −5 → res_sign 1, res_mag 2, overflow 0.
- Subtract to zero: −6 sub −6 → res_sign 0, res_mag 0, zero_flag 1.
- Negative zero: −0 add +0 → res_sign 0, res_mag 0, zero_flag 1.
- Overflow: +9 add +9 → res_mag 2, overflow 1, res_sign 0. Also −8 sub +8 → res_mag 0, overflow 1, zero_flag 1, res_sign 1.
- Backpressure: hold out_ready low for 3 cycles in DONE → outputs unchanged and in_ready 0 for the whole hold. Release it → handshake completes, in_ready is 1 on the next cycle, and a back-to-back op is accepted correctly.
- Reset mid-operation: pulse rst_n low mid-CALC, asynchronously → all outputs go to 0 without waiting for a clock edge, in_ready 1, and no stale out_valid appears. The next op, +1 add +1, yields +2.

Source files
------------

// File: rtl/sm_alu_pkg.sv
// Shared types and constants for the bit-serial sign-magnitude add/subtract unit.
package sm_alu_pkg;

    // Operation sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_e;

    // Encoding of the op input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Width of the bit counter that walks 0..mag_w-1 (at least one bit)
    function automatic int cnt_width(input int mag_w);
        return (mag_w > 1) ? $clog2(mag_w) : 1;
    endfunction

endpackage

// File: rtl/sm_serial_bit.sv
// One-bit full adder / full subtractor used by the serial datapath.
// mode_i = 0: sum_o = m + s + cb_i, cb_o = carry out.
// mode_i = 1: sum_o = m - s - cb_i, cb_o = borrow out.
module sm_serial_bit (
    input  logic m_i,
    input  logic s_i,
    input  logic cb_i,
    input  logic mode_i,
    output logic sum_o,
    output logic cb_o
);

    // Sum/difference bit is identical for add and subtract; only the carry/borrow differs
    always_comb begin
        sum_o = m_i ^ s_i ^ cb_i;
        if (mode_i) begin
            cb_o = (~m_i & (s_i | cb_i)) | (s_i & cb_i);
        end else begin
            cb_o = (m_i & s_i) | (m_i & cb_i) | (s_i & cb_i);
        end
    end

endmodule

// File: rtl/sm_serial_alu.sv
// Bit-serial sign-magnitude add/subtract unit with valid/ready handshakes.
// The larger magnitude is always routed to the minuend in CMP, so the
// serial subtraction never ends with a borrow and the sign is fixed up front.
module sm_serial_alu
    import sm_alu_pkg::*;
#(
    parameter int MAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [MAG_W-1:0] a_mag,
    input  logic [MAG_W-1:0] b_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_sign,
    output logic [MAG_W-1:0] res_mag,
    output logic             overflow,
    output logic             zero_flag
);

    localparam int CW = cnt_width(MAG_W);

    state_e             state_q, state_d;
    logic [MAG_W-1:0]   min_sr_q;      // minuend / first addend, shifts right
    logic [MAG_W-1:0]   sub_sr_q;      // subtrahend / second addend, shifts right
    logic [MAG_W-1:0]   res_sr_q;      // result bits enter at the MSB
    logic [MAG_W-1:0]   res_sr_d;
    logic               a_sign_q;
    logic               eb_q;          // effective sign of B after applying op
    logic               mode_q;        // 1 = magnitudes are subtracted
    logic               sign_q;        // provisional result sign chosen in CMP
    logic               carry_q;
    logic [CW-1:0]      cnt_q;
    logic               res_sign_q;
    logic [MAG_W-1:0]   res_mag_q;
    logic               overflow_q;
    logic               zero_q;

    logic               accept_s;
    logic               last_bit_s;
    logic               a_ge_b_s;
    logic               sum_s;
    logic               cb_s;
    logic               ovf_s;
    logic               res_zero_s;

    assign accept_s   = (state_q == IDLE) && in_valid;
    assign last_bit_s = (state_q == CALC) && (cnt_q == CW'(MAG_W - 1));
    assign a_ge_b_s   = (min_sr_q >= sub_sr_q);

    sm_serial_bit u_bit (
        .m_i    (min_sr_q[0]),
        .s_i    (sub_sr_q[0]),
        .cb_i   (carry_q),
        .mode_i (mode_q),
        .sum_o  (sum_s),
        .cb_o   (cb_s)
    );

    // Result shift-in and final flag derivation for the bit being produced
    always_comb begin
        res_sr_d   = {sum_s, res_sr_q[MAG_W-1:1]};
        ovf_s      = ~mode_q & cb_s;
        res_zero_s = (res_sr_d == {MAG_W{1'b0}});
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CMP;
                end else begin
                    state_d = IDLE;
                end
            end
            CMP: begin
                state_d = CALC;
            end
            CALC: begin
                if (cnt_q == CW'(MAG_W - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Operand capture, swap, serial shifting, carry/borrow and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_sr_q <= {MAG_W{1'b0}};
            sub_sr_q <= {MAG_W{1'b0}};
            res_sr_q <= {MAG_W{1'b0}};
            a_sign_q <= 1'b0;
            eb_q     <= 1'b0;
            mode_q   <= 1'b0;
            sign_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= CW'(0);
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        min_sr_q <= a_mag;
                        sub_sr_q <= b_mag;
                        a_sign_q <= a_sign;
                        eb_q     <= b_sign ^ (op == OP_SUB);
                    end
                end
                CMP: begin
                    // Larger magnitude becomes the minuend so the difference is non-negative
                    if (!a_ge_b_s) begin
                        min_sr_q <= sub_sr_q;
                        sub_sr_q <= min_sr_q;
                    end
                    mode_q  <= (a_sign_q != eb_q);
                    if ((a_sign_q != eb_q) && !a_ge_b_s) begin
                        sign_q <= eb_q;
                    end else begin
                        sign_q <= a_sign_q;
                    end
                    carry_q <= 1'b0;
                    cnt_q   <= CW'(0);
                end
                CALC: begin
                    min_sr_q <= {1'b0, min_sr_q[MAG_W-1:1]};
                    sub_sr_q <= {1'b0, sub_sr_q[MAG_W-1:1]};
                    res_sr_q <= res_sr_d;
                    carry_q  <= cb_s;
                    if (!last_bit_s) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    carry_q <= carry_q;
                end
            endcase
        end
    end

    // Result and flag registers, loaded once when the last bit is produced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sign_q <= 1'b0;
            res_mag_q  <= {MAG_W{1'b0}};
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (last_bit_s) begin
            res_mag_q  <= res_sr_d;
            overflow_q <= ovf_s;
            zero_q     <= res_zero_s;
            // A true zero is always +0; a wrapped-to-zero overflow keeps the operand sign
            res_sign_q <= sign_q & ~(res_zero_s & ~ovf_s);
        end
    end

    assign res_sign  = res_sign_q;
    assign res_mag   = res_mag_q;
    assign overflow  = overflow_q;
    assign zero_flag = zero_q;

endmodule
